// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: decimates ADC samples into the FFT core, collects the
// output bins, and writes |re|+|im| bar heights for the lower half-spectrum
// into the bar framebuffer. Runs back-to-back frames while enable is high.
module fft_frame_ctrl #(
  parameter int N_LOG2   = 5,
  parameter int SAMPLE_W = 12,
  parameter int XK_W     = 8,
  parameter int BAR_W    = 4,
  parameter int DECIM    = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [SAMPLE_W-1:0]     sample_data,
  output logic                    fft_start,
  output logic                    fft_xn_valid,
  output logic signed [XK_W-1:0]  fft_xn_re,
  input  logic                    fft_busy,
  input  logic                    fft_xk_valid,
  input  logic signed [XK_W-1:0]  fft_xk_re,
  input  logic signed [XK_W-1:0]  fft_xk_im,
  output logic                    bin_we,
  output logic [N_LOG2-2:0]       bin_addr,
  output logic [BAR_W-1:0]        bin_value,
  output logic                    frame_done,
  output logic                    timeout_err
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [N_LOG2-1:0] CNT_LAST = '1;
  localparam logic [XK_W:0]     BAR_MAX  = (XK_W + 1)'((1 << BAR_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_UNLOAD,
    S_DONE
  } state_t;

  // Offset-binary ADC code to two's complement, keeping the top XK_W bits.
  function automatic logic signed [XK_W-1:0] to_signed(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: XK_W-1]};
  endfunction

  // Absolute value one bit wider so that the most negative code stays exact.
  function automatic logic [XK_W:0] abs_ext(input logic signed [XK_W-1:0] v);
    logic [XK_W:0] w;
    w = {v[XK_W-1], v};
    return v[XK_W-1] ? (~w + 1'b1) : w;
  endfunction

  // Scale the L1 magnitude down to bar range and clip at full scale.
  function automatic logic [BAR_W-1:0] sat_bar(input logic [XK_W:0] s);
    logic [XK_W:0] q;
    q = s >> (XK_W - BAR_W);
    if (q > BAR_MAX) return '1;
    return q[BAR_W-1:0];
  endfunction

  state_t              state;
  logic [DEC_W-1:0]    dec_cnt;
  logic [N_LOG2-1:0]   smp_cnt;
  logic [N_LOG2-1:0]   bin_cnt;
  logic [TMR_W-1:0]    timer;
  logic                accept;
  logic                beat;
  logic [N_LOG2-1:0]   beat_idx;
  logic [BAR_W-1:0]    bar_p0;
  logic                unused_lsbs;

  // Low ADC bits are below FFT input precision and are intentionally dropped.
  assign unused_lsbs = ^sample_data[SAMPLE_W-XK_W-1:0];

  assign accept   = sample_valid && (dec_cnt == '0);
  // The beat that moves WAIT to UNLOAD is itself bin 0.
  assign beat     = fft_xk_valid && ((state == S_WAIT) || (state == S_UNLOAD));
  assign beat_idx = (state == S_WAIT) ? '0 : bin_cnt;
  assign bar_p0   = sat_bar(abs_ext(fft_xk_re) + abs_ext(fft_xk_im));

  // Free-running decimator: counts every sample strobe regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (sample_valid) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
    end
  end

  // Frame FSM with registered strobes; bar write lands one cycle after its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      smp_cnt      <= '0;
      bin_cnt      <= '0;
      timer        <= '0;
      fft_start    <= 1'b0;
      fft_xn_valid <= 1'b0;
      fft_xn_re    <= '0;
      bin_we       <= 1'b0;
      bin_addr     <= '0;
      bin_value    <= '0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      fft_start    <= 1'b0;
      fft_xn_valid <= 1'b0;
      bin_we       <= 1'b0;
      frame_done   <= 1'b0;

      // Stage p0 -> output: magnitude of the current beat registered as a bar write
      if (beat) begin
        bin_we    <= ~beat_idx[N_LOG2-1];
        bin_addr  <= beat_idx[N_LOG2-2:0];
        bin_value <= bar_p0;
      end

      case (state)
        S_IDLE: begin
          if (enable && !fft_busy) begin
            fft_start   <= 1'b1;
            timeout_err <= 1'b0;
            smp_cnt     <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            fft_xn_valid <= 1'b1;
            fft_xn_re    <= to_signed(sample_data);
            smp_cnt      <= smp_cnt + 1'b1;
            if (smp_cnt == CNT_LAST) begin
              timer <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (fft_xk_valid) begin
            bin_cnt <= N_LOG2'(1);
            state   <= S_UNLOAD;
          end else if (timer == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (fft_xk_valid) begin
            bin_cnt <= bin_cnt + 1'b1;
            if (bin_cnt == CNT_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: stimulus pushes expected FFT inputs
// and bar writes into queues, a negedge monitor pops and compares them.
module tb_fft_frame_ctrl;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              sample_valid;
  logic [11:0]       sample_data;
  logic              fft_start;
  logic              fft_xn_valid;
  logic signed [7:0] fft_xn_re;
  logic              fft_busy;
  logic              fft_xk_valid;
  logic [7:0]        fft_xk_re;
  logic [7:0]        fft_xk_im;
  logic              bin_we;
  logic [3:0]        bin_addr;
  logic [3:0]        bin_value;
  logic              frame_done;
  logic              timeout_err;

  fft_frame_ctrl #(
    .N_LOG2(5), .SAMPLE_W(12), .XK_W(8), .BAR_W(4), .DECIM(4), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .fft_start(fft_start), .fft_xn_valid(fft_xn_valid), .fft_xn_re(fft_xn_re),
    .fft_busy(fft_busy), .fft_xk_valid(fft_xk_valid),
    .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .bin_we(bin_we), .bin_addr(bin_addr), .bin_value(bin_value),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int cyc;

  logic [7:0]  xn_q[$];
  logic [7:0]  bin_q[$];
  logic [11:0] smp_tab[32];
  logic [7:0]  exp_xn_tab[32];
  logic [7:0]  re_tab[32];
  logic [7:0]  im_tab[32];
  logic [3:0]  val_tab[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fft_xn_valid) begin
        if (xn_q.size() == 0) chk("xn_unexpected", {31'b0, fft_xn_valid}, 0);
        else chk("xn_re", {24'b0, fft_xn_re}, {24'b0, xn_q.pop_front()});
      end
      if (bin_we) begin
        if (bin_q.size() == 0) chk("bin_unexpected", {31'b0, bin_we}, 0);
        else chk("bin_addr_value", {24'b0, bin_addr, bin_value}, {24'b0, bin_q.pop_front()});
      end
      if (fft_start) start_cnt++;
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string nm);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fft_start) break;
    end
    chk(nm, {31'b0, fft_start}, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk(nm, {31'b0, frame_done}, 1);
  endtask

  // Every 4th pulse (phase 0) is accepted; rejected pulses carry 0xFFF.
  task automatic load_frame(input int npulses, input int drop_at);
    for (int i = 0; i < npulses; i++) begin
      if (i > 0) tick();
      if (i % 4 == 0) begin
        sample_data = smp_tab[i/4];
        xn_q.push_back(exp_xn_tab[i/4]);
      end else begin
        sample_data = 12'hFFF;
      end
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      if (i % 4 == 0 && i / 4 == drop_at) enable = 1'b0;
    end
  endtask

  task automatic unload(input int nbeats, input int npush);
    for (int k = 0; k < nbeats; k++) begin
      fft_xk_valid = 1'b1;
      fft_xk_re    = re_tab[k];
      fft_xk_im    = im_tab[k];
      if (k < npush && k < 16) bin_q.push_back({4'(k), val_tab[k]});
      tick();
    end
    fft_xk_valid = 1'b0;
  endtask

  task automatic fill_bins(input logic [7:0] re, input logic [7:0] im, input logic [3:0] v);
    for (int k = 0; k < 32; k++) begin
      re_tab[k] = re; im_tab[k] = im; val_tab[k] = v;
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; fft_busy = 1'b0;
    sample_valid = 1'b0; sample_data = '0;
    fft_xk_valid = 1'b0; fft_xk_re = '0; fft_xk_im = '0;

    // Reset state and first start pulse
    @(negedge clk);
    chk("reset_outputs", {8'b0, fft_start, fft_xn_valid, fft_xn_re, bin_we, bin_addr,
                          bin_value, frame_done, timeout_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("start_before", {31'b0, fft_start}, 0);
    @(negedge clk); chk("start_pulse", {31'b0, fft_start}, 1);
    chk("others_idle", {29'b0, fft_xn_valid, bin_we, frame_done}, 0);
    @(negedge clk); chk("start_one_cycle", {31'b0, fft_start}, 0);

    // Frame 1: conversion and magnitude patterns
    for (int g = 0; g < 32; g++) begin smp_tab[g] = 12'h800; exp_xn_tab[g] = 8'h00; end
    smp_tab[5] = 12'hFFF; exp_xn_tab[5] = 8'h7F;
    smp_tab[6] = 12'h000; exp_xn_tab[6] = 8'h80;
    smp_tab[7] = 12'hABC; exp_xn_tab[7] = 8'h2B;
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) begin re_tab[k] = 8'h80; im_tab[k] = 8'h80; val_tab[k] = 4'd15; end
      else begin re_tab[k] = 8'h10; im_tab[k] = 8'hF0; val_tab[k] = 4'd2; end
    end
    re_tab[3]  = 8'h7F; im_tab[3]  = 8'h00; val_tab[3]  = 4'd7;
    re_tab[4]  = 8'hFF; im_tab[4]  = 8'h01; val_tab[4]  = 4'd0;
    re_tab[5]  = 8'h30; im_tab[5]  = 8'hC0; val_tab[5]  = 4'd7;
    re_tab[9]  = 8'h81; im_tab[9]  = 8'h81; val_tab[9]  = 4'd15;
    re_tab[11] = 8'h0F; im_tab[11] = 8'h00; val_tab[11] = 4'd0;
    re_tab[15] = 8'h40; im_tab[15] = 8'h40; val_tab[15] = 4'd8;
    @(posedge clk); #1;
    fft_xk_valid = 1'b1; fft_xk_re = 8'h80; fft_xk_im = 8'h80;
    tick();
    fft_xk_valid = 1'b0;
    load_frame(128, 99);
    chk("xn_all_seen_f1", xn_q.size(), 0);
    unload(32, 16);
    wait_done("frame_done_f1");
    chk("bins_all_seen_f1", bin_q.size(), 0);

    // Frame 2: starts automatically; enable dropped at accepted sample 10
    wait_start("start_f2");
    for (int g = 0; g < 32; g++) begin smp_tab[g] = 12'h800; exp_xn_tab[g] = 8'h00; end
    fill_bins(8'h10, 8'hF0, 4'd2);
    @(posedge clk); #1;
    load_frame(128, 10);
    unload(32, 16);
    wait_done("frame_done_f2");
    chk("bins_all_seen_f2", bin_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("no_restart_disabled", start_cnt, 2);

    // Frame 3: no FFT output -> timeout abort
    @(posedge clk); #1 enable = 1'b1;
    wait_start("start_f3");
    enable = 1'b0;
    @(posedge clk); #1;
    load_frame(125, 99);
    for (cyc = 1; cyc <= 1100; cyc++) begin
      tick();
      if (timeout_err) break;
    end
    chk("timeout_cycles", cyc, 1023);
    repeat (5) tick();
    chk("timeout_sticky", {31'b0, timeout_err}, 1);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; sample_data = 12'h123;
      tick();
      sample_valid = 1'b0;
      tick();
    end
    chk("xn_none_in_idle", xn_q.size(), 0);

    // Frame 4: busy hold-off, start clears error, async reset during unload
    fft_busy = 1'b1; enable = 1'b1;
    repeat (6) tick();
    chk("busy_holdoff", start_cnt, 3);
    fft_busy = 1'b0;
    wait_start("start_f4");
    chk("start_clears_err", {31'b0, timeout_err}, 0);
    for (int g = 0; g < 32; g++) begin smp_tab[g] = 12'h800; exp_xn_tab[g] = 8'h00; end
    fill_bins(8'h80, 8'h80, 4'd15);
    @(posedge clk); #1;
    enable = 1'b0;
    load_frame(128, 99);
    unload(6, 5);
    chk("we_before_reset", {31'b0, bin_we}, 1);
    #1 rst_n = 1'b0;
    #1 chk("we_async_reset", {31'b0, bin_we}, 0);
    chk("reset_outputs_mid", {8'b0, fft_start, fft_xn_valid, fft_xn_re, bin_we, bin_addr,
                              bin_value, frame_done, timeout_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();

    chk("xn_queue_empty", xn_q.size(), 0);
    chk("bin_queue_empty", bin_q.size(), 0);
    chk("start_count", start_cnt, 4);
    chk("done_count", done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer between the Pmod ADC sample stream, the FFT core (fft_inst) and the spectrum bar framebuffer (fb_inst).
- Decimates incoming ADC samples and converts them to signed FFT input.
- Starts the FFT and streams one N-point frame into it, then collects the N output bins.
- Reduces each of the first N/2 bins to a bar height and writes it into the framebuffer; repeats while enabled.

Parameters:
- N_LOG2, 5, log2 of FFT points (N=32).
- SAMPLE_W, 12, ADC sample width, unsigned offset-binary.
- XK_W, 8, FFT input/output width, two's complement.
- BAR_W, 4, framebuffer set_value width.
- DECIM, 4, accept one sample out of every DECIM valid samples (DECIM>=1).
- TIMEOUT, 1023, max cycles waiting for FFT output before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run continuous frames while high
- sample_valid  in  1  ADC sample strobe, one cycle
- sample_data  in  SAMPLE_W  ADC sample
- fft_start  out  1  one-cycle FFT start pulse
- fft_xn_valid  out  1  FFT input data valid
- fft_xn_re  out  XK_W  FFT real input (imag tied 0 externally)
- fft_busy  in  1  FFT computing
- fft_xk_valid  in  1  FFT output bin valid
- fft_xk_re  in  XK_W  bin real part
- fft_xk_im  in  XK_W  bin imaginary part
- bin_we  out  1  framebuffer write strobe
- bin_addr  out  N_LOG2-1  bar index 0..N/2-1
- bin_value  out  BAR_W  bar height (set_value)
- frame_done  out  1  one-cycle pulse after last bar write
- timeout_err  out  1  sticky, set on abort, cleared by fft_start

Behaviour:
- Reset: all outputs 0.
  - State = IDLE; decimation and sample/bin counters = 0.
- Decimator: counts sample_valid pulses modulo DECIM and is always running. A sample is accepted when the count is 0.
- Conversion: fft_xn_re = {~sample_data[SAMPLE_W-1], sample_data[SAMPLE_W-2 -: XK_W-1]}, i.e. offset-binary to signed, top XK_W bits.
- FSM:
  - IDLE: if enable, assert fft_start for 1 cycle, clear timeout_err, go to LOAD.
  - LOAD: each accepted sample drives fft_xn_valid=1 with fft_xn_re registered (1-cycle latency from sample_valid). Count 0..N-1; after the Nth, go to WAIT.
  - WAIT: timer counts from 0. On fft_xk_valid, go to UNLOAD, processing that same beat as bin 0. If the timer reaches TIMEOUT, set timeout_err and go to IDLE.
  - UNLOAD: count bins 0..N-1 on fft_xk_valid beats.
    - Bins 0..N/2-1 produce bin_we=1 one cycle after the beat, with bin_addr = bin index.
    - Bins N/2..N-1 are consumed without writes.
    - After bin N-1 is consumed, go to DONE.
  - DONE: frame_done=1 for 1 cycle; go to IDLE. A new frame starts the next cycle if enable is still high.
- Magnitude:
  - S = |re| + |im| computed at XK_W+1 bits; |-2^(XK_W-1)| = 2^(XK_W-1) is exact.
  - bin_value = min(S >> (XK_W-BAR_W), 2^BAR_W-1).
- enable deasserted mid-frame: the current frame completes; the FSM stays in IDLE afterwards.
- sample_valid outside LOAD is ignored for data, but still advances the decimator.
- fft_xk_valid outside WAIT/UNLOAD is ignored.
- fft_busy is informational only. In IDLE with fft_busy=1, fft_start is held off until fft_busy=0.
- Async reset mid-frame: immediate return to reset values; no partial bin_we.

Test Plan:
- Reset held, then released with enable=1 and fft_busy=0 -> fft_start pulses exactly 1 cycle, one cycle after release; all other outputs stay 0.
- DECIM=4, 128 sample_valid pulses with sample_data=0x800 -> exactly 32 fft_xn_valid pulses, each with fft_xn_re=0x00. Input 0xFFF -> 0x7F; input 0x000 -> 0x80.
- 32 output beats with re=0x80, im=0x80 -> S=256, bin_value=15 (saturated). With re=0x10, im=0xF0 (-16) -> S=32, bin_value=2.
- 32 output beats -> bin_we exactly 16 times at addresses 0..15, then frame_done pulses once.
- No fft_xk_valid after LOAD -> timeout_err=1 at TIMEOUT cycles; next fft_start clears it.
- enable dropped during LOAD at sample 10 -> frame completes all 16 writes, then no further fft_start. Assert rst_n low during UNLOAD -> bin_we=0 immediately.
